// File: rtl/enc_8to3_rr.sv
// rtl/enc_8to3_rr.sv - round-robin 8-to-3 event encoder with pending capture
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   word     in   8  event bits, each set bit captured into pend every edge
//   ready    in   1  consumer accepts a when valid is also high
//   clr_ovf  in   1  synchronous clear of the sticky overflow flag
//   a        out  3  index of the granted pending bit (registered)
//   valid    out  1  a holds an unconsumed index (registered)
//   pend_cnt out  4  popcount of the pending register, 0..8 (registered)
//   ovf      out  1  sticky: an event arrived on an already-pending bit

module enc_8to3_rr (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] word,
   input  logic       ready,
   input  logic       clr_ovf,
   output logic [2:0] a,
   output logic       valid,
   output logic [3:0] pend_cnt,
   output logic       ovf
);

   logic [7:0] pend;
   logic [2:0] ptr;

   logic       free;
   logic       sel_found;
   logic [2:0] sel_idx;
   logic [2:0] cand;
   logic       grant;
   logic [7:0] grant_mask;
   logic [7:0] pend_next;
   logic [3:0] cnt_next;
   logic       ovf_set;

   // Output slot can take a new index when empty or being consumed this edge.
   assign free = !valid || ready;

   // Search pend upward from ptr with wrap; the first set bit wins.
   // Selection looks only at pend as it stands before this edge's word merge.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = 3'd0;
      cand      = 3'd0;
      for (int j = 0; j < 8; j++) begin
         cand = ptr + 3'(j);
         if (!sel_found && pend[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign grant      = free && sel_found;
   assign grant_mask = grant ? (8'd1 << sel_idx) : 8'd0;
   assign pend_next  = (pend & ~grant_mask) | word;

   // A re-arrival on the bit being granted this edge is not a loss: the old
   // event leaves and the new one takes its place.
   assign ovf_set = |(word & pend & ~grant_mask);

   always_comb begin
      cnt_next = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt_next = cnt_next + {3'd0, pend_next[i]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend     <= 8'd0;
         ptr      <= 3'd0;
         a        <= 3'd0;
         valid    <= 1'b0;
         pend_cnt <= 4'd0;
         ovf      <= 1'b0;
      end else begin
         pend     <= pend_next;
         pend_cnt <= cnt_next;

         if (free) begin
            valid <= grant;
            if (grant) begin
               a   <= sel_idx;
               ptr <= sel_idx + 3'd1;
            end
         end

         // Set beats clear when both happen on the same edge.
         if (ovf_set) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_enc_8to3_rr.sv
// tb/tb_enc_8to3_rr.sv - directed self-checking bench for enc_8to3_rr

module tb_enc_8to3_rr;

   logic       clk;
   logic       rst;
   logic [7:0] word;
   logic       ready;
   logic       clr_ovf;
   logic [2:0] a;
   logic       valid;
   logic [3:0] pend_cnt;
   logic       ovf;

   int total;
   int bad;

   enc_8to3_rr dut (
      .clk      (clk),
      .rst      (rst),
      .word     (word),
      .ready    (ready),
      .clr_ovf  (clr_ovf),
      .a        (a),
      .valid    (valid),
      .pend_cnt (pend_cnt),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [8:0] exp;
      // Fill pend and make valid=1 with ready held low.
      word = 8'hFF; ready = 1'b0;
      step();
      step();
      exp = {3'd0, 1'b1, 4'd8, 1'b1};
      total++;
      if ({a, valid, pend_cnt, ovf} !== exp) begin
         $display("FAIL reset_preload a/valid/cnt/ovf got=%h want=%h", {a, valid, pend_cnt, ovf}, exp);
         bad++;
      end
      #3 rst = 1'b1;
      #1;
      exp = 9'd0;
      total++;
      if ({a, valid, pend_cnt, ovf} !== exp) begin
         $display("FAIL reset_async a/valid/cnt/ovf got=%h want=%h", {a, valid, pend_cnt, ovf}, exp);
         bad++;
      end
      word = 8'h00;
      #2 rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if ({a, valid, pend_cnt, ovf} !== exp) begin
            $display("FAIL reset_idle%0d a/valid/cnt/ovf got=%h want=%h", i, {a, valid, pend_cnt, ovf}, exp);
            bad++;
         end
      end
   endtask

   task automatic test_burst();
      word = 8'hFF; ready = 1'b1;
      step();
      word = 8'h00;
      total++;
      if (valid !== 1'b0 || pend_cnt !== 4'd8) begin
         $display("FAIL burst_capture valid=%b cnt=%0d want valid=0 cnt=8", valid, pend_cnt);
         bad++;
      end
      for (int i = 0; i < 8; i++) begin
         step();
         total++;
         if (a !== 3'(i) || valid !== 1'b1 || pend_cnt !== 4'(7 - i)) begin
            $display("FAIL burst_grant%0d a=%0d valid=%b cnt=%0d want a=%0d valid=1 cnt=%0d",
                     i, a, valid, pend_cnt, i, 7 - i);
            bad++;
         end
      end
      step();
      total++;
      if (valid !== 1'b0 || a !== 3'd7) begin
         $display("FAIL burst_drain valid=%b a=%0d want valid=0 a=7", valid, a);
         bad++;
      end
      // ptr must have wrapped to 0: bits 0 and 7 grant as 0 then 7.
      word = 8'h81;
      step();
      word = 8'h00;
      step();
      total++;
      if (a !== 3'd0 || valid !== 1'b1) begin
         $display("FAIL burst_wrap_first a=%0d valid=%b want a=0 valid=1", a, valid);
         bad++;
      end
      step();
      total++;
      if (a !== 3'd7 || valid !== 1'b1) begin
         $display("FAIL burst_wrap_second a=%0d valid=%b want a=7 valid=1", a, valid);
         bad++;
      end
      step();
   endtask

   task automatic test_single();
      word = 8'b0000_0100; ready = 1'b1;
      step();
      word = 8'h00;
      total++;
      if (pend_cnt !== 4'd1 || valid !== 1'b0) begin
         $display("FAIL single_capture cnt=%0d valid=%b want cnt=1 valid=0", pend_cnt, valid);
         bad++;
      end
      step();
      total++;
      if (a !== 3'd2 || valid !== 1'b1 || pend_cnt !== 4'd0) begin
         $display("FAIL single_grant a=%0d valid=%b cnt=%0d want a=2 valid=1 cnt=0", a, valid, pend_cnt);
         bad++;
      end
      step();
      total++;
      if (valid !== 1'b0 || a !== 3'd2) begin
         $display("FAIL single_done valid=%b a=%0d want valid=0 a=2", valid, a);
         bad++;
      end
   endtask

   task automatic test_rr_wrap();
      word = 8'h20; ready = 1'b1;
      step();
      word = 8'h00;
      step();
      total++;
      if (a !== 3'd5 || valid !== 1'b1) begin
         $display("FAIL rr_grant5 a=%0d valid=%b want a=5 valid=1", a, valid);
         bad++;
      end
      word = 8'b0100_0001;
      step();
      word = 8'h00;
      step();
      total++;
      if (a !== 3'd6 || valid !== 1'b1) begin
         $display("FAIL rr_first a=%0d valid=%b want a=6 valid=1", a, valid);
         bad++;
      end
      step();
      total++;
      if (a !== 3'd0 || valid !== 1'b1) begin
         $display("FAIL rr_second a=%0d valid=%b want a=0 valid=1", a, valid);
         bad++;
      end
      step();
   endtask

   task automatic test_backpressure();
      word = 8'h08; ready = 1'b1;
      step();
      word = 8'h00; ready = 1'b0;
      step();
      total++;
      if (a !== 3'd3 || valid !== 1'b1) begin
         $display("FAIL bp_setup a=%0d valid=%b want a=3 valid=1", a, valid);
         bad++;
      end
      word = 8'h10;
      step();
      total++;
      if (a !== 3'd3 || valid !== 1'b1 || pend_cnt !== 4'd1 || ovf !== 1'b0) begin
         $display("FAIL bp_first a=%0d valid=%b cnt=%0d ovf=%b want a=3 valid=1 cnt=1 ovf=0",
                  a, valid, pend_cnt, ovf);
         bad++;
      end
      word = 8'h00;
      step();
      total++;
      if (a !== 3'd3 || valid !== 1'b1 || pend_cnt !== 4'd1) begin
         $display("FAIL bp_gap a=%0d valid=%b cnt=%0d want a=3 valid=1 cnt=1", a, valid, pend_cnt);
         bad++;
      end
      word = 8'h10;
      step();
      word = 8'h00;
      total++;
      if (a !== 3'd3 || pend_cnt !== 4'd1 || ovf !== 1'b1) begin
         $display("FAIL bp_second a=%0d cnt=%0d ovf=%b want a=3 cnt=1 ovf=1", a, pend_cnt, ovf);
         bad++;
      end
      ready = 1'b1;
      step();
      total++;
      if (a !== 3'd4 || valid !== 1'b1 || pend_cnt !== 4'd0 || ovf !== 1'b1) begin
         $display("FAIL bp_release a=%0d valid=%b cnt=%0d ovf=%b want a=4 valid=1 cnt=0 ovf=1",
                  a, valid, pend_cnt, ovf);
         bad++;
      end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      total++;
      if (ovf !== 1'b0 || valid !== 1'b0) begin
         $display("FAIL bp_clr ovf=%b valid=%b want ovf=0 valid=0", ovf, valid);
         bad++;
      end
   endtask

   task automatic test_coincident();
      word = 8'h01; ready = 1'b1;
      step();
      total++;
      if (pend_cnt !== 4'd1 || valid !== 1'b0) begin
         $display("FAIL coin_capture cnt=%0d valid=%b want cnt=1 valid=0", pend_cnt, valid);
         bad++;
      end
      step();
      word = 8'h00;
      total++;
      if (a !== 3'd0 || valid !== 1'b1 || pend_cnt !== 4'd1 || ovf !== 1'b0) begin
         $display("FAIL coin_grant a=%0d valid=%b cnt=%0d ovf=%b want a=0 valid=1 cnt=1 ovf=0",
                  a, valid, pend_cnt, ovf);
         bad++;
      end
      step();
      total++;
      if (a !== 3'd0 || valid !== 1'b1 || pend_cnt !== 4'd0 || ovf !== 1'b0) begin
         $display("FAIL coin_second a=%0d valid=%b cnt=%0d ovf=%b want a=0 valid=1 cnt=0 ovf=0",
                  a, valid, pend_cnt, ovf);
         bad++;
      end
      step();
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1; word = 8'h00; ready = 1'b0; clr_ovf = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      test_reset();
      test_burst();
      test_single();
      test_rr_wrap();
      test_backpressure();
      test_coincident();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/enc_8to3_rr.md
# enc_8to3_rr

Round-robin 8-to-3 encoder that is the inverse of the 3-to-8 decoder. It captures event bits on an 8-bit one-hot or multi-hot word into a pending register. It then emits each pending bit, one per transfer, as a 3-bit index on a valid/ready output. It sits between event sources and the index consumers that drive the decoder side.

## Interface
- No parameters; input width is fixed at 8 and code width at 3.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- word  input  8  event bits; each set bit is sampled once per rising edge.
- ready  input  1  consumer accepts `a` this cycle when `valid` is also 1.
- clr_ovf  input  1  synchronous clear of the sticky overflow flag.
- a  output  3  encoded index of the granted bit (registered).
- valid  output  1  `a` holds an unconsumed index (registered).
- pend_cnt  output  4  popcount of the pending register, range 0..8 (registered).
- ovf  output  1  sticky flag: an event was lost because its pending bit was already set.

## Operation
- State:
  - `pend[7:0]`: pending events.
  - `ptr[2:0]`: round-robin start position.
  - Output register: `a`, `valid`.
  - `ovf`.
- Slot free: `free = !valid || ready`.
- Selection when `free` and `pend != 0`:
  - Choose the first set bit of `pend` searching upward from `ptr` with wrap, in order ptr, ptr+1, …, 7, 0, …, ptr-1.
  - Load its index k into `a`, set `valid=1`, clear `pend[k]`, set `ptr = (k+1) mod 8` (7 wraps to 0).
- `free` and `pend == 0`: `valid` goes to 0; `a` holds its last value.
- Not `free` (`valid && !ready`):
  - `a`, `valid`, `ptr` hold.
  - No pending bit is cleared.
- Pending update per edge: `pend_next = (pend & ~grant_mask) | word`. `grant_mask` is the one-hot of the selected k, or 0 when nothing is selected.
- Selection uses `pend` before this edge's `word` merge. A bit arriving on `word` is never granted in the same edge.
- Overflow:
  - `ovf` sets when `word[i] && pend[i] && !grant_mask[i]` for any i.
  - When `word[i]` coincides with `grant_mask[i]`, the old event is granted, the new one stays pending, and this is not overflow.
  - `clr_ovf` clears `ovf`. A set condition in the same cycle as `clr_ovf` wins, so `ovf` stays 1.
- `pend_cnt` = popcount(`pend_next`), registered; it always equals the popcount of the current `pend`.
- Reset (asynchronous, any time including mid-transfer): `pend=0`, `ptr=0`, `a=3'd0`, `valid=0`, `pend_cnt=0`, `ovf=0`. An unconsumed `a` is discarded.

## Timing
- Latency: `word[i]` high at edge E0 is captured into `pend`. With the slot free, `a=i` and `valid=1` become visible after edge E1, which is 1 cycle after capture.
- Throughput: one index per cycle while `ready=1` and `pend` is non-empty. No bubble between consecutive grants.
- A transfer completes on an edge where `valid && ready`. The next index, if any, appears after that same edge.
- While `valid && !ready`, `a` is stable across edges. This is a hard requirement checked by the bench.
- `pend_cnt` and `ovf` update on the same edge as `pend`.

## Test plan
- Reset:
  - Assert `rst` mid-cycle with `pend=8'hFF` and `valid=1`.
  - Required response: immediately `a=0`, `valid=0`, `pend_cnt=0`, `ovf=0`.
  - After release with `word=0`: all outputs stay 0.
- Single event:
  - `word=8'b0000_0100` for one cycle with `ready=1`.
  - Required response: `pend_cnt=1` after the capture edge; next edge `a=3'd2`, `valid=1`, `pend_cnt=0`; following edge `valid=0`.
- Burst:
  - `word=8'hFF` for one cycle with `ready=1` and `ptr=0`.
  - Required response: `a` = 0,1,2,…,7 on 8 consecutive cycles with `valid=1` throughout.
  - `pend_cnt` sequence: 8,7,…,0.
  - Then `valid=0` and `ptr=0` (wrapped).
- Round-robin wrap:
  - After granting index 5, apply `word=8'b0100_0001`.
  - Required response: grants in order 6 then 0, not 0 then 6.
- Backpressure and overflow:
  - Hold `ready=0` with `a=3` and `valid=1`; apply `word=8'h10` twice, one cycle apart.
  - Required response: `a=3` stable; `pend_cnt=1`; `ovf=1` after the second edge.
  - Raise `ready`: `a=4` next.
  - Pulse `clr_ovf`: `ovf=0`.
- Coincident grant and arrival:
  - `pend=8'h01`, slot free, `word=8'h01` on the grant edge.
  - Required response: `a=0`, `pend_cnt` stays 1, `ovf` stays 0, and a second `a=0` follows.
